// File: rtl/qam_pkg.sv
// Shared definitions for the QAM mapper: modulation codes, per-mode symbol
// geometry (bits per symbol, bits per axis) and the Gray-to-binary helper.
package qam_pkg;

  typedef logic [2:0] mod_t;

  localparam mod_t MOD_BPSK = 3'd0;
  localparam mod_t MOD_QPSK = 3'd1;
  localparam mod_t MOD_16   = 3'd2;
  localparam mod_t MOD_64   = 3'd3;
  localparam mod_t MOD_256  = 3'd4;
  localparam mod_t MOD_1024 = 3'd5;
  localparam mod_t MOD_4096 = 3'd6;

  // The reserved code 7 behaves as BPSK.
  function automatic mod_t mode_norm(input mod_t modtyp);
    return (modtyp > MOD_4096) ? MOD_BPSK : modtyp;
  endfunction

  function automatic logic [3:0] bps_of(input mod_t modtyp);
    case (modtyp)
      MOD_QPSK: return 4'd2;
      MOD_16:   return 4'd4;
      MOD_64:   return 4'd6;
      MOD_256:  return 4'd8;
      MOD_1024: return 4'd10;
      MOD_4096: return 4'd12;
      default:  return 4'd1;
    endcase
  endfunction

  function automatic logic [2:0] k_of(input mod_t modtyp);
    case (modtyp)
      MOD_16:   return 3'd2;
      MOD_64:   return 3'd3;
      MOD_256:  return 3'd4;
      MOD_1024: return 3'd5;
      MOD_4096: return 3'd6;
      default:  return 3'd1;
    endcase
  endfunction

  function automatic logic [5:0] gray2bin(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/qam_mapper_if.sv
// Streaming bundle of the QAM mapper: word input, mode select, I/Q output and
// buffer status. The mapper takes the slave view, its environment the master.
interface qam_mapper_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16
);
  logic [DATA_W-1:0]       data;
  logic                    data_valid;
  logic                    data_ready;
  logic [2:0]              modtyp;
  logic signed [OUT_W-1:0] inphase;
  logic signed [OUT_W-1:0] quadrature;
  logic                    sym_valid;
  logic                    sym_ready;
  logic                    dbufempt;

  modport master (
    output data, data_valid, modtyp, sym_ready,
    input  data_ready, inphase, quadrature, sym_valid, dbufempt
  );

  modport slave (
    input  data, data_valid, modtyp, sym_ready,
    output data_ready, inphase, quadrature, sym_valid, dbufempt
  );
endinterface

// File: rtl/qam_level_map.sv
// One constellation axis: k-bit field -> odd level scaled to OUT_W signed.
// Build option QAM_GRAY_EN selects Gray-coded mapping; otherwise natural binary.
module qam_level_map
  import qam_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic [5:0]              field,
  input  logic [2:0]              k,
  output logic signed [OUT_W-1:0] sample
);

  logic [5:0]              idx;
  logic signed [OUT_W-1:0] twice_idx;
  logic signed [OUT_W-1:0] peak;
  logic signed [OUT_W-1:0] level;

  always_comb begin
`ifdef QAM_GRAY_EN
    idx = gray2bin(field);
`else
    idx = field;
`endif
    twice_idx = OUT_W'({idx, 1'b0});
    peak      = OUT_W'((7'd1 << k) - 7'd1);
    level     = twice_idx - peak;
    // Shift by OUT_W-2-k keeps the peak below 2^(OUT_W-2) for every mode.
    sample    = level <<< (OUT_W - 2 - int'(k));
  end

endmodule

// File: rtl/qam_mapper.sv
// QAM symbol mapper (BPSK..4096-QAM): LSB-first bit buffer feeding a
// handshaked I/Q output register. Mapping order set by QAM_GRAY_EN.
module qam_mapper
  import qam_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16
) (
  input logic         dclk,
  input logic         rst,
  qam_mapper_if.slave bus
);

  localparam int BUF_W  = 2 * DATA_W;
  localparam int FILL_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0]        buf_q, buf_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  mod_t                    mode_q, mode_d;
  logic signed [OUT_W-1:0] inphase_q, inphase_d;
  logic signed [OUT_W-1:0] quadrature_q, quadrature_d;
  logic                    sym_valid_q, sym_valid_d;

  logic [FILL_W-1:0]       bps;
  logic [FILL_W-1:0]       fill_mid;
  logic [2:0]              k;
  logic [5:0]              mask, field_i, field_q;
  logic signed [OUT_W-1:0] lvl_i, lvl_q;
  logic                    acc, ld;

  assign bus.data_ready = !rst && (fill_q <= FILL_W'(DATA_W));
  assign bus.dbufempt   = fill_q < bps;
  assign bus.inphase    = inphase_q;
  assign bus.quadrature = quadrature_q;
  assign bus.sym_valid  = sym_valid_q;

  qam_level_map #(.OUT_W(OUT_W)) u_map_i (.field(field_i), .k(k), .sample(lvl_i));
  qam_level_map #(.OUT_W(OUT_W)) u_map_q (.field(field_q), .k(k), .sample(lvl_q));

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    k       = k_of(mode_q);
    bps     = FILL_W'(bps_of(mode_q));
    mask    = (6'd1 << k) - 6'd1;
    field_i = buf_q[5:0] & mask;
    field_q = 6'(buf_q >> k) & mask;

    acc = bus.data_valid && bus.data_ready;
    ld  = (fill_q >= bps) && (!sym_valid_q || bus.sym_ready);

    buf_d    = buf_q;
    fill_mid = fill_q;
    if (ld) begin
      buf_d    = buf_q >> bps;
      fill_mid = fill_q - bps;
    end
    // Bits above fill are always zero, so the new word can be OR-ed in place.
    if (acc) buf_d = buf_d | (BUF_W'(bus.data) << fill_mid);
    fill_d = fill_mid + (acc ? FILL_W'(DATA_W) : '0);

    mode_d = ((fill_q == '0) && !acc) ? mode_norm(bus.modtyp) : mode_q;

    inphase_d    = inphase_q;
    quadrature_d = quadrature_q;
    sym_valid_d  = sym_valid_q;
    if (ld) begin
      inphase_d    = lvl_i;
      quadrature_d = (mode_q == MOD_BPSK) ? '0 : lvl_q;
      sym_valid_d  = 1'b1;
    end else if (bus.sym_ready) begin
      sym_valid_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      buf_q        <= '0;
      fill_q       <= '0;
      mode_q       <= MOD_BPSK;
      inphase_q    <= '0;
      quadrature_q <= '0;
      sym_valid_q  <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      mode_q       <= mode_d;
      inphase_q    <= inphase_d;
      quadrature_q <= quadrature_d;
      sym_valid_q  <= sym_valid_d;
    end
  end

endmodule
